// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the byte-serial add/sub sequencer
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int BYTE_W = 8;
    function automatic int idx_w(input int nbytes);
        return (nbytes < 2) ? 1 : $clog2(nbytes);
    endfunction
endpackage

// File: rtl/addsub8_unit.sv
// addsub8_unit: combinational 8-bit adder exposing carry into and out of bit 7
module addsub8_unit
    import addsub_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              c7
);
    logic [BYTE_W-1:0] lo;
    assign lo = {1'b0, a[BYTE_W-2:0]} + {1'b0, b[BYTE_W-2:0]} + {{(BYTE_W-1){1'b0}}, cin};
    assign c7 = lo[BYTE_W-1];
    assign sum[BYTE_W-2:0] = lo[BYTE_W-2:0];
    assign {cout, sum[BYTE_W-1]} = {1'b0, a[BYTE_W-1]} + {1'b0, b[BYTE_W-1]} + {1'b0, c7};
endmodule

// File: rtl/addsub_serial_ctrl.sv
// addsub_serial_ctrl: multi-byte add/sub sequenced LSB-first through one 8-bit unit
module addsub_serial_ctrl
    import addsub_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] op_a,
    input  logic [BYTE_W*NBYTES-1:0] op_b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     c_out,
    output logic                     over_flow
);
    localparam int IW = idx_w(NBYTES);
    state_t state, state_nx;
    logic [NBYTES-1:0][BYTE_W-1:0] a_q, b_q, res_q;
    logic [IW-1:0] idx;
    logic sub_q, carry_q, c_out_q, ov_q, last;
    logic [BYTE_W-1:0] sum;
    logic cout, c7;

    addsub8_unit u_unit (
        .a   (a_q[idx]),
        .b   (b_q[idx] ^ {BYTE_W{sub_q}}),
        .cin (carry_q),
        .sum (sum),
        .cout(cout),
        .c7  (c7)
    );

    assign last = idx == IW'(NBYTES - 1);

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                   (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
            c_out_q <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_q     <= op_a;
                b_q     <= op_b;
                sub_q   <= sub;
                carry_q <= sub;
                idx     <= '0;
            end
            if (state == RUN) begin
                res_q[idx] <= sum;
                carry_q    <= cout;
                idx        <= idx + 1'b1;
                if (last) begin
                    c_out_q <= cout;
                    ov_q    <= c7 ^ cout;
                end
            end
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign result    = res_q;
    assign c_out     = c_out_q;
    assign over_flow = ov_q;
endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// tb_addsub_serial_ctrl: randomized and directed checks against an arithmetic reference model
module tb_addsub_serial_ctrl;
    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic in_ready, out_valid, c_out, over_flow;
    logic [W-1:0] result;
    int checks = 0, failures = 0;

    addsub_serial_ctrl #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .c_out(c_out), .over_flow(over_flow)
    );

    always #5 clk = ~clk;

    // reference model: the full-width result is computed at acceptance and revealed NBYTES edges later
    int m_cnt = 0;
    bit m_init = 0, m_done = 0, m_clear = 0;
    logic [W-1:0] m_r, p_r;
    logic m_c, m_o, p_c, p_o;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1; m_cnt = 0; m_done = 0; m_clear = 1;
            m_r = '0; m_c = 0; m_o = 0;
        end else if (m_cnt == 0 && !m_done) begin
            if (in_valid) begin
                {p_c, p_r} = sub ? {1'b0, op_a} + {1'b0, ~op_b} + 1 : {1'b0, op_a} + {1'b0, op_b};
                p_o = sub ? (op_a[W-1] != op_b[W-1] && p_r[W-1] != op_a[W-1])
                          : (op_a[W-1] == op_b[W-1] && p_r[W-1] != op_a[W-1]);
                m_cnt = NBYTES; m_clear = 0;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1; m_r = p_r; m_c = p_c; m_o = p_o;
            end
        end else if (out_ready) begin
            m_done = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", in_ready, m_cnt == 0 && !m_done);
            chk("out_valid", out_valid, m_done);
            if (m_cnt == 0) begin
                chk("c_out", c_out, m_c);
                chk("over_flow", over_flow, m_o);
            end
            if (m_done || m_clear) chk("result", result, m_r);
        end
    end

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < NBYTES; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold, output logic [W-1:0] r, output logic c,
                          output logic o, output int lat);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("wait_in_ready", in_ready, 1);
        op_a = a; op_b = b; sub = s; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0; op_a = rnd(); op_b = rnd(); sub = ~s;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("wait_out_valid", out_valid, 1);
        r = result; c = c_out; o = over_flow;
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            chk("bp_hold_result", result, r);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    logic [W-1:0] r;
    logic c, o;
    int lat;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);

        run_op(32'h00000055, 32'h00000044, 0, 0, r, c, o, lat);
        chk("add1_r", r, 32'h00000099); chk("add1_c", c, 0); chk("add1_o", o, 0);
        chk("add1_latency", lat, NBYTES);
        run_op(32'hFFFFFFFF, 32'h00000001, 0, 0, r, c, o, lat);
        chk("add2_r", r, 32'h00000000); chk("add2_c", c, 1); chk("add2_o", o, 0);
        run_op(32'h7FFFFFFF, 32'h00000001, 0, 0, r, c, o, lat);
        chk("add3_r", r, 32'h80000000); chk("add3_c", c, 0); chk("add3_o", o, 1);
        run_op(32'h00000011, 32'h00000055, 1, 0, r, c, o, lat);
        chk("sub1_r", r, 32'hFFFFFFBC); chk("sub1_c", c, 0); chk("sub1_o", o, 0);
        run_op(32'h80000000, 32'h00000001, 1, 5, r, c, o, lat);
        chk("sub2_r", r, 32'h7FFFFFFF); chk("sub2_c", c, 1); chk("sub2_o", o, 1);

        op_a = 32'h12345678; op_b = 32'h11111111; sub = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        run_op(32'h12345678, 32'h11111111, 1, 0, r, c, o, lat);
        chk("after_abort_r", r, 32'h01234567); chk("after_abort_c", c, 1);

        for (int i = 0; i < 1500; i++) begin
            rst_n = $urandom_range(0, 79) != 0;
            in_valid = 1'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            sub = 1'($urandom);
            op_a = ($urandom_range(0, 7) == 0) ? {1'b0, {(W-1){1'b1}}} : rnd();
            op_b = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : rnd();
            @(posedge clk); #1;
        end
        rst_n = 1; in_valid = 0; out_ready = 1;
        repeat (NBYTES + 3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
